gdb_rsp_packet_rx: RTL and testbench

Receive-side framer for the GDB Remote Serial Protocol. It sits directly downstream of the socket byte receive path and consumes the raw byte stream received from the GDB client. It hunts for `$payload#xx` frames, un-escapes the payload and verifies the modulo-256 checksum. Only verified payloads are released to the command decoder; the matching `+`/`-` acknowledge byte goes to the socket send path, and out-of-band Ctrl-C and ack bytes are reported.

---
 rtl/gdb_rsp_packet_rx.sv | 212 +++++++++++++++++++++
 tb/tb_gdb_rsp_packet_rx.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gdb_rsp_packet_rx.sv
// GDB RSP receive framer: hunts for $payload#xx, un-escapes and checksums the
// payload, answers with '+'/'-' and releases verified payloads to the decoder.
module gdb_rsp_packet_rx #(
    parameter int DEPTH = 256,
    parameter bit NOACK = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_vld,
    output logic       rx_rdy,
    input  logic [7:0] rx_dat,
    output logic       pkt_vld,
    input  logic       pkt_rdy,
    output logic [7:0] pkt_dat,
    output logic       pkt_lst,
    output logic       ack_vld,
    input  logic       ack_rdy,
    output logic [7:0] ack_dat,
    output logic       brk,
    output logic       rsp_ack,
    output logic       rsp_nak,
    output logic       err_cs,
    output logic       err_ovf
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic [2:0] {
        S_IDLE, S_DATA, S_ESC, S_CS_HI, S_CS_LO, S_ACK, S_DRAIN
    } state_t;

    state_t          state_q, state_d;
    logic [7:0]      sum_q, sum_d;
    logic [LW-1:0]   len_q, len_d, rd_q, rd_d;
    logic            ovf_q, ovf_d, bad_q, bad_d, good_q, good_d;
    logic [3:0]      cs_hi_q, cs_hi_d;
    logic            brk_q, brk_d, rsp_ack_q, rsp_ack_d, rsp_nak_q, rsp_nak_d;
    logic            err_cs_q, err_cs_d, err_ovf_q, err_ovf_d;

    logic [7:0]      mem [DEPTH];
    logic [7:0]      rdata_q;
    logic            wr_en, rd_en, st_req, rx_fire, bad_now, cs_match;
    logic [7:0]      st_dat;
    logic [AW-1:0]   rd_addr;
    logic [4:0]      hex;

    // {valid, nibble} for one ASCII hex digit
    function automatic logic [4:0] hex_dec(input logic [7:0] c);
        if (c >= 8'h30 && c <= 8'h39)
            return {1'b1, c[3:0]};
        else if ((c >= 8'h61 && c <= 8'h66) || (c >= 8'h41 && c <= 8'h46))
            return {1'b1, c[3:0] + 4'd9};
        else
            return 5'd0;
    endfunction

    assign rx_rdy   = (state_q != S_ACK) && (state_q != S_DRAIN);
    assign rx_fire  = rx_vld && rx_rdy;
    assign hex      = hex_dec(rx_dat);
    assign bad_now  = bad_q || !hex[4];
    assign cs_match = ({cs_hi_q, hex[3:0]} == sum_q);

    always_comb begin
        state_d   = state_q;
        sum_d     = sum_q;
        len_d     = len_q;
        rd_d      = rd_q;
        ovf_d     = ovf_q;
        bad_d     = bad_q;
        good_d    = good_q;
        cs_hi_d   = cs_hi_q;
        brk_d     = 1'b0;
        rsp_ack_d = 1'b0;
        rsp_nak_d = 1'b0;
        err_cs_d  = 1'b0;
        err_ovf_d = 1'b0;
        st_req    = 1'b0;
        st_dat    = rx_dat;
        wr_en     = 1'b0;
        rd_en     = 1'b0;
        rd_addr   = rd_q[AW-1:0];
        ack_vld   = 1'b0;
        pkt_vld   = 1'b0;
        pkt_lst   = 1'b0;

        case (state_q)
            S_IDLE: if (rx_fire) begin
                if (rx_dat == 8'h24) begin
                    state_d = S_DATA;
                    sum_d   = 8'd0;
                    len_d   = '0;
                    ovf_d   = 1'b0;
                end
                brk_d     = (rx_dat == 8'h03);
                rsp_ack_d = (rx_dat == 8'h2B);
                rsp_nak_d = (rx_dat == 8'h2D);
            end
            S_DATA: if (rx_fire) begin
                if (rx_dat == 8'h23) begin
                    state_d = S_CS_HI;
                end else if (rx_dat == 8'h24) begin
                    sum_d = 8'd0;
                    len_d = '0;
                    ovf_d = 1'b0;
                end else begin
                    sum_d = sum_q + rx_dat;
                    if (rx_dat == 8'h7D) state_d = S_ESC;
                    else                 st_req  = 1'b1;
                end
            end
            S_ESC: if (rx_fire) begin
                sum_d   = sum_q + rx_dat;
                st_req  = 1'b1;
                st_dat  = rx_dat ^ 8'h20;
                state_d = S_DATA;
            end
            S_CS_HI: if (rx_fire) begin
                bad_d   = !hex[4];
                cs_hi_d = hex[3:0];
                state_d = S_CS_LO;
            end
            S_CS_LO: if (rx_fire) begin
                good_d    = cs_match && !bad_now && !ovf_q;
                err_cs_d  = !cs_match || bad_now;
                err_ovf_d = ovf_q;
                state_d   = S_ACK;
            end
            S_ACK: begin
                ack_vld = !NOACK;
                if (NOACK || ack_rdy) begin
                    if (good_q && len_q != '0) begin
                        // prefetch beat 0 so it is valid on the first DRAIN cycle
                        state_d = S_DRAIN;
                        rd_d    = '0;
                        rd_en   = 1'b1;
                        rd_addr = '0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_DRAIN: begin
                pkt_vld = 1'b1;
                pkt_lst = (rd_q == len_q - LW'(1));
                if (pkt_rdy) begin
                    if (pkt_lst) begin
                        state_d = S_IDLE;
                    end else begin
                        rd_d    = rd_q + LW'(1);
                        rd_en   = 1'b1;
                        rd_addr = rd_d[AW-1:0];
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (st_req) begin
            if (len_q < LW'(DEPTH)) begin
                wr_en = 1'b1;
                len_d = len_q + LW'(1);
            end else begin
                ovf_d = 1'b1;
            end
        end
    end

    assign ack_dat = ack_vld ? (good_q ? 8'h2B : 8'h2D) : 8'h00;
    assign pkt_dat = pkt_vld ? rdata_q : 8'h00;
    assign brk     = brk_q;
    assign rsp_ack = rsp_ack_q;
    assign rsp_nak = rsp_nak_q;
    assign err_cs  = err_cs_q;
    assign err_ovf = err_ovf_q;

    always_ff @(posedge clk) begin
        if (wr_en) mem[len_q[AW-1:0]] <= st_dat;
        if (rd_en) rdata_q <= mem[rd_addr];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            sum_q     <= 8'd0;
            len_q     <= '0;
            rd_q      <= '0;
            ovf_q     <= 1'b0;
            bad_q     <= 1'b0;
            good_q    <= 1'b0;
            cs_hi_q   <= 4'd0;
            brk_q     <= 1'b0;
            rsp_ack_q <= 1'b0;
            rsp_nak_q <= 1'b0;
            err_cs_q  <= 1'b0;
            err_ovf_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sum_q     <= sum_d;
            len_q     <= len_d;
            rd_q      <= rd_d;
            ovf_q     <= ovf_d;
            bad_q     <= bad_d;
            good_q    <= good_d;
            cs_hi_q   <= cs_hi_d;
            brk_q     <= brk_d;
            rsp_ack_q <= rsp_ack_d;
            rsp_nak_q <= rsp_nak_d;
            err_cs_q  <= err_cs_d;
            err_ovf_q <= err_ovf_d;
        end
    end
endmodule

// File: tb/tb_gdb_rsp_packet_rx.sv
// Bench for gdb_rsp_packet_rx: directed and random byte streams, checked
// against a byte-level protocol model (ack, payload beats and pulse events).
module tb_gdb_rsp_packet_rx;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic drv_vld = 1'b0, drv_prdy = 1'b1, drv_ardy = 1'b1;
    logic [7:0] drv_dat = 8'h00;
    bit na_sel = 1'b0;
    int bp_mode = 0;

    logic m_rx_rdy, m_pkt_vld, m_pkt_lst, m_ack_vld, m_brk, m_rsp_ack, m_rsp_nak, m_err_cs, m_err_ovf;
    logic n_rx_rdy, n_pkt_vld, n_pkt_lst, n_ack_vld, n_brk, n_rsp_ack, n_rsp_nak, n_err_cs, n_err_ovf;
    logic [7:0] m_pkt_dat, m_ack_dat, n_pkt_dat, n_ack_dat;

    always #5 clk = ~clk;

    gdb_rsp_packet_rx #(.DEPTH(DEPTH), .NOACK(1'b0)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .rx_vld(drv_vld && !na_sel), .rx_rdy(m_rx_rdy), .rx_dat(drv_dat),
        .pkt_vld(m_pkt_vld), .pkt_rdy(drv_prdy), .pkt_dat(m_pkt_dat), .pkt_lst(m_pkt_lst),
        .ack_vld(m_ack_vld), .ack_rdy(drv_ardy), .ack_dat(m_ack_dat),
        .brk(m_brk), .rsp_ack(m_rsp_ack), .rsp_nak(m_rsp_nak),
        .err_cs(m_err_cs), .err_ovf(m_err_ovf));

    gdb_rsp_packet_rx #(.DEPTH(DEPTH), .NOACK(1'b1)) u_dut_noack (
        .clk(clk), .rst_n(rst_n),
        .rx_vld(drv_vld && na_sel), .rx_rdy(n_rx_rdy), .rx_dat(drv_dat),
        .pkt_vld(n_pkt_vld), .pkt_rdy(drv_prdy), .pkt_dat(n_pkt_dat), .pkt_lst(n_pkt_lst),
        .ack_vld(n_ack_vld), .ack_rdy(drv_ardy), .ack_dat(n_ack_dat),
        .brk(n_brk), .rsp_ack(n_rsp_ack), .rsp_nak(n_rsp_nak),
        .err_cs(n_err_cs), .err_ovf(n_err_ovf));

    // view of whichever instance is currently being exercised
    logic c_rx_rdy, c_pkt_vld, c_pkt_lst, c_ack_vld;
    logic [7:0] c_pkt_dat, c_ack_dat;
    logic [4:0] c_evt;
    assign c_rx_rdy  = na_sel ? n_rx_rdy  : m_rx_rdy;
    assign c_pkt_vld = na_sel ? n_pkt_vld : m_pkt_vld;
    assign c_pkt_lst = na_sel ? n_pkt_lst : m_pkt_lst;
    assign c_pkt_dat = na_sel ? n_pkt_dat : m_pkt_dat;
    assign c_ack_vld = na_sel ? n_ack_vld : m_ack_vld;
    assign c_ack_dat = na_sel ? n_ack_dat : m_ack_dat;
    assign c_evt = na_sel ? {n_err_ovf, n_err_cs, n_rsp_nak, n_rsp_ack, n_brk}
                          : {m_err_ovf, m_err_cs, m_rsp_nak, m_rsp_ack, m_brk};

    int total = 0, bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // observed and expected transaction streams
    logic [7:0] obs_ack[$], exp_ack[$];
    logic [8:0] obs_pkt[$], exp_pkt[$];
    int         obs_evt[$], exp_evt[$];

    // ---------------- reference model ----------------
    int         md = 0;
    logic [7:0] m_pl[$];
    logic [7:0] m_sum;
    int         m_hi;
    bit         m_bad;

    function automatic int hexv(input logic [7:0] c);
        if (c >= "0" && c <= "9") return int'(c) - 48;
        if (c >= "a" && c <= "f") return int'(c) - 87;
        if (c >= "A" && c <= "F") return int'(c) - 55;
        return -1;
    endfunction

    task automatic model_byte(input logic [7:0] b);
        int v, cs;
        bit bad2, good;
        case (md)
            0: begin
                if (b == "$") begin md = 1; m_pl.delete(); m_sum = 0; end
                else if (b == 8'h03) exp_evt.push_back(1);
                else if (b == "+") exp_evt.push_back(2);
                else if (b == "-") exp_evt.push_back(3);
            end
            1: begin
                if (b == "#") md = 3;
                else if (b == "$") begin m_pl.delete(); m_sum = 0; end
                else if (b == "}") begin m_sum = m_sum + b; md = 2; end
                else begin m_sum = m_sum + b; m_pl.push_back(b); end
            end
            2: begin m_sum = m_sum + b; m_pl.push_back(b ^ 8'h20); md = 1; end
            3: begin v = hexv(b); m_bad = (v < 0); m_hi = (v < 0) ? 0 : v; md = 4; end
            default: begin
                v = hexv(b);
                bad2 = m_bad || (v < 0);
                cs = m_hi * 16 + ((v < 0) ? 0 : v);
                good = !bad2 && (cs == int'(m_sum)) && (m_pl.size() <= DEPTH);
                if (bad2 || cs != int'(m_sum)) exp_evt.push_back(4);
                if (m_pl.size() > DEPTH) exp_evt.push_back(5);
                if (!na_sel) exp_ack.push_back(good ? "+" : "-");
                if (good)
                    for (int i = 0; i < m_pl.size(); i++)
                        exp_pkt.push_back({i == m_pl.size() - 1, m_pl[i]});
                md = 0;
            end
        endcase
    endtask

    // ---------------- monitor ----------------
    logic p_ack_stall = 1'b0, p_pkt_stall = 1'b0;
    logic [7:0] p_ack_dat, p_pkt_dat;
    logic p_pkt_lst;

    always @(negedge clk) begin
        if (!rst_n) begin
            p_ack_stall = 1'b0;
            p_pkt_stall = 1'b0;
        end else begin
            if (c_ack_vld && drv_ardy) obs_ack.push_back(c_ack_dat);
            if (c_pkt_vld && drv_prdy) obs_pkt.push_back({c_pkt_lst, c_pkt_dat});
            for (int i = 0; i < 5; i++) if (c_evt[i]) obs_evt.push_back(i + 1);
            if (p_ack_stall) chk("ack_hold", {c_ack_vld, c_ack_dat}, {1'b1, p_ack_dat});
            if (p_pkt_stall) chk("pkt_hold", {c_pkt_vld, c_pkt_lst, c_pkt_dat}, {1'b1, p_pkt_lst, p_pkt_dat});
            if (c_ack_vld || c_pkt_vld) chk("rx_rdy_busy", c_rx_rdy, 0);
            if (na_sel) chk("noack_vld", n_ack_vld, 0);
            p_ack_stall = c_ack_vld && !drv_ardy;
            p_pkt_stall = c_pkt_vld && !drv_prdy;
            p_ack_dat = c_ack_dat;
            p_pkt_dat = c_pkt_dat;
            p_pkt_lst = c_pkt_lst;
        end
    end

    // ready drivers for the downstream ack/pkt ports
    initial begin
        int hold = 0;
        forever begin
            @(posedge clk);
            #2;
            case (bp_mode)
                1: begin
                    drv_ardy = ($urandom_range(0, 3) != 0);
                    drv_prdy = ($urandom_range(0, 2) != 0);
                end
                2: begin
                    hold = c_ack_vld ? hold + 1 : 0;
                    drv_ardy = (hold > 5);
                    drv_prdy = ~drv_prdy;
                end
                default: begin drv_ardy = 1'b1; drv_prdy = 1'b1; end
            endcase
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send_byte(input logic [7:0] b, input int gap);
        int n = 0;
        drv_dat = b;
        drv_vld = 1'b1;
        while (!c_rx_rdy && n < 2000) begin @(negedge clk); n++; end
        if (n >= 2000) begin
            chk("rx_timeout", 0, 1);
            drv_vld = 1'b0;
            return;
        end
        @(posedge clk);
        model_byte(b);
        @(negedge clk);
        drv_vld = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic send_str(input string s, input int gapmax);
        for (int i = 0; i < s.len(); i++) send_byte(s[i], $urandom_range(0, gapmax));
    endtask

    logic [7:0] tx_pl[$];

    task automatic set_pl(input string s);
        tx_pl.delete();
        for (int i = 0; i < s.len(); i++) tx_pl.push_back(s[i]);
    endtask

    function automatic logic [7:0] hexch(input logic [3:0] nib);
        logic [7:0] base;
        if (nib < 10) return 8'h30 + 8'(nib);
        base = $urandom_range(0, 1) ? 8'h41 : 8'h61;
        return base + 8'(nib) - 8'd10;
    endfunction

    // cmode 0: good checksum, 1: wrong checksum, 2: one invalid hex digit
    task automatic send_pkt(input int cmode, input int gapmax);
        logic [7:0] raw[$];
        logic [7:0] s, c;
        s = 8'd0;
        raw.push_back("$");
        foreach (tx_pl[i]) begin
            c = tx_pl[i];
            if (c == "#" || c == "$" || c == "}" || $urandom_range(0, 5) == 0) begin
                raw.push_back("}");
                raw.push_back(c ^ 8'h20);
                s = s + 8'h7D + (c ^ 8'h20);
            end else begin
                raw.push_back(c);
                s = s + c;
            end
        end
        raw.push_back("#");
        if (cmode == 1) s = s + 8'd1;
        raw.push_back(hexch(s[7:4]));
        raw.push_back(hexch(s[3:0]));
        if (cmode == 2) raw[raw.size() - 1 - $urandom_range(0, 1)] = "g";
        foreach (raw[i]) send_byte(raw[i], $urandom_range(0, gapmax));
    endtask

    task automatic settle_and_compare(input string tag);
        int n = 0;
        while ((obs_ack.size() < exp_ack.size() || obs_pkt.size() < exp_pkt.size()) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        repeat (4) @(negedge clk);
        chk({tag, "_nack"}, obs_ack.size(), exp_ack.size());
        chk({tag, "_npkt"}, obs_pkt.size(), exp_pkt.size());
        chk({tag, "_nevt"}, obs_evt.size(), exp_evt.size());
        for (int i = 0; i < exp_ack.size() && i < obs_ack.size(); i++) chk({tag, "_ack"}, obs_ack[i], exp_ack[i]);
        for (int i = 0; i < exp_pkt.size() && i < obs_pkt.size(); i++) chk({tag, "_pkt"}, obs_pkt[i], exp_pkt[i]);
        for (int i = 0; i < exp_evt.size() && i < obs_evt.size(); i++) chk({tag, "_evt"}, obs_evt[i], exp_evt[i]);
        $display("txn %s: acks=%0d beats=%0d events=%0d", tag, exp_ack.size(), exp_pkt.size(), exp_evt.size());
        obs_ack.delete(); exp_ack.delete();
        obs_pkt.delete(); exp_pkt.delete();
        obs_evt.delete(); exp_evt.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_rx_rdy"}, {m_rx_rdy, n_rx_rdy}, 2'b11);
        chk({tag, "_outs"}, {m_ack_vld, m_pkt_vld, m_pkt_lst, m_brk, m_rsp_ack, m_rsp_nak,
                             m_err_cs, m_err_ovf, m_ack_dat, m_pkt_dat}, 0);
        chk({tag, "_outs_na"}, {n_ack_vld, n_pkt_vld, n_pkt_lst, n_brk, n_rsp_ack, n_rsp_nak,
                                n_err_cs, n_err_ovf, n_ack_dat, n_pkt_dat}, 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        send_str("$m0,4#fd", 0);
        settle_and_compare("m0_4");

        send_str("$g#00", 0);
        settle_and_compare("bad_cs");
        send_str("$g#67", 0);
        settle_and_compare("g_ok");

        send_byte(8'h03, 0); send_str("+-x", 0);
        settle_and_compare("oob");
        send_str("$X}", 0); send_byte(8'h03, 0); send_str("#d8", 0);
        settle_and_compare("esc_brk");

        set_pl("m0,4a"); send_pkt(0, 0);
        settle_and_compare("ovf");
        send_str("$abcd#8a", 0);
        settle_and_compare("full");

        bp_mode = 2;
        send_str("$m0,4#fd", 0);
        send_str("$abcd#8a", 0);
        settle_and_compare("backpressure");
        bp_mode = 0;

        na_sel = 1'b1;
        send_str("$abcd#8a", 0);
        send_str("$g#00", 0);
        settle_and_compare("noack");
        na_sel = 1'b0;

        send_str("$m0,", 0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid_reset");
        md = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send_str("$g#67", 0);
        settle_and_compare("after_reset");

        bp_mode = 1;
        for (int it = 0; it < 60; it++) begin
            int nlen, pick;
            na_sel = ($urandom_range(0, 4) == 0);
            for (int k = $urandom_range(0, 2); k > 0; k--) begin
                pick = $urandom_range(0, 4);
                case (pick)
                    0: send_byte(8'h03, $urandom_range(0, 1));
                    1: send_byte("+", $urandom_range(0, 1));
                    2: send_byte("-", $urandom_range(0, 1));
                    3: send_byte("x", $urandom_range(0, 1));
                    default: send_byte(8'h80 + 8'($urandom_range(0, 127)), 0);
                endcase
            end
            if ($urandom_range(0, 5) == 0) send_str("$zz", 1);
            nlen = $urandom_range(0, 6);
            tx_pl.delete();
            for (int k = 0; k < nlen; k++) begin
                pick = $urandom_range(0, 7);
                case (pick)
                    0: tx_pl.push_back("#");
                    1: tx_pl.push_back("$");
                    2: tx_pl.push_back("}");
                    3: tx_pl.push_back(8'h03);
                    default: tx_pl.push_back(8'($urandom_range(0, 255)));
                endcase
            end
            pick = $urandom_range(0, 9);
            send_pkt((pick < 7) ? 0 : ((pick < 9) ? 1 : 2), 2);
            settle_and_compare($sformatf("rand%0d", it));
        end
        na_sel = 1'b0;
        bp_mode = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
